buscaminas_game_ctrl: RTL

Parametrised game controller for the Buscaminas (Minesweeper) lab. It sequences the game through idle, mine placement, play, move evaluation and win/lose. It counts safe cells revealed and enforces a per-move time limit. It sits between the input/debounce front end, the mine-placement/board-memory block and the VGA renderer, which decodes `state`.

---
 rtl/buscaminas_pkg.sv | 20 ++
 rtl/turn_timer.sv | 38 +++
 rtl/buscaminas_game_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/buscaminas_pkg.sv
// Shared game-state encodings for the Buscaminas controller and the VGA state decoder.
package buscaminas_pkg;

    localparam logic [2:0] ST_IDLE  = 3'b000;
    localparam logic [2:0] ST_SETUP = 3'b001;
    localparam logic [2:0] ST_PLAY  = 3'b010;
    localparam logic [2:0] ST_EVAL  = 3'b011;
    localparam logic [2:0] ST_WIN   = 3'b100;
    localparam logic [2:0] ST_LOSE  = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_SETUP = ST_SETUP,
        S_PLAY  = ST_PLAY,
        S_EVAL  = ST_EVAL,
        S_WIN   = ST_WIN,
        S_LOSE  = ST_LOSE
    } game_state_e;

endpackage

// File: rtl/turn_timer.sv
// Per-move down-counter: load sets the value, en decrements it, zero flags an empty count.
module turn_timer #(
    parameter int TICK_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [TICK_W-1:0] load_val_i,
    input  logic              en_i,
    output logic [TICK_W-1:0] count_o,
    output logic              zero_o
);

    logic [TICK_W-1:0] count_q, count_d;

    // Load has priority; decrement saturates at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - TICK_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/buscaminas_game_ctrl.sv
// Minesweeper game sequencer: setup handshake, move evaluation, reveal counting, per-move timeout.
//
//  state | meaning
//  IDLE  | waiting for start with a legal mine count
//  SETUP | mine placement requested
//  PLAY  | accepting a move; ticks count the move timer down
//  EVAL  | one cycle judging the captured move
//  WIN   | all safe cells revealed (terminal until start)
//  LOSE  | mine hit or move timed out (terminal until start)
module buscaminas_game_ctrl
    import buscaminas_pkg::*;
#(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int MAX_MINES  = 15,
    parameter int TURN_TICKS = 10,
    parameter int MINE_W     = $clog2(MAX_MINES + 1),
    parameter int CELL_W     = $clog2(ROWS * COLS + 1),
    parameter int TICK_W     = $clog2(TURN_TICKS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [MINE_W-1:0] mines,
    input  logic              place_done,
    input  logic              move_valid,
    input  logic              cell_is_mine,
    input  logic              cell_is_open,
    input  logic              tick,
    output logic              move_ready,
    output logic              place_req,
    output logic [MINE_W-1:0] mine_count,
    output logic [CELL_W-1:0] revealed,
    output logic [TICK_W-1:0] time_left,
    output logic [2:0]        state,
    output logic              win,
    output logic              lose
);

    if (MAX_MINES >= ROWS * COLS) begin : g_bad_cfg
        $error("buscaminas_game_ctrl: MAX_MINES must be below ROWS*COLS");
    end

    game_state_e       state_q, state_d;
    logic [MINE_W-1:0] mine_count_q, mine_count_d;
    logic [CELL_W-1:0] revealed_q, revealed_d;
    logic              cap_mine_q, cap_mine_d;
    logic              cap_open_q, cap_open_d;

    logic              tmr_load;
    logic [TICK_W-1:0] tmr_val;
    logic              tmr_en;
    logic [TICK_W-1:0] tmr_count;
    logic              tmr_zero;

    logic [CELL_W-1:0] safe_total;
    logic [CELL_W-1:0] revealed_inc;

    assign safe_total   = CELL_W'(ROWS * COLS) - CELL_W'(mine_count_q);
    assign revealed_inc = revealed_q + CELL_W'(1);

    // Next-state logic, counter updates and timer control.
    always_comb begin
        state_d      = state_q;
        mine_count_d = mine_count_q;
        revealed_d   = revealed_q;
        cap_mine_d   = cap_mine_q;
        cap_open_d   = cap_open_q;
        tmr_load     = 1'b0;
        tmr_val      = '0;
        tmr_en       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && (mines != '0) && (mines <= MINE_W'(MAX_MINES))) begin
                    state_d      = S_SETUP;
                    mine_count_d = mines;
                end
            end
            S_SETUP: begin
                if (place_done) begin
                    state_d    = S_PLAY;
                    revealed_d = '0;
                    tmr_load   = 1'b1;
                    tmr_val    = TICK_W'(TURN_TICKS);
                end
            end
            S_PLAY: begin
                // A move in the same cycle as a tick swallows the tick.
                if (move_valid) begin
                    state_d    = S_EVAL;
                    cap_mine_d = cell_is_mine;
                    cap_open_d = cell_is_open;
                end else if (tick) begin
                    tmr_en = 1'b1;
                    if (tmr_count == TICK_W'(1)) begin
                        state_d = S_LOSE;
                    end
                end else if (tmr_zero) begin
                    state_d = S_LOSE;
                end
            end
            S_EVAL: begin
                if (cap_mine_q) begin
                    state_d = S_LOSE;
                end else if (cap_open_q) begin
                    state_d = S_PLAY;
                end else begin
                    revealed_d = revealed_inc;
                    if (revealed_inc == safe_total) begin
                        state_d = S_WIN;
                    end else begin
                        state_d  = S_PLAY;
                        tmr_load = 1'b1;
                        tmr_val  = TICK_W'(TURN_TICKS);
                    end
                end
            end
            S_WIN, S_LOSE: begin
                if (start) begin
                    state_d    = S_IDLE;
                    revealed_d = '0;
                    tmr_load   = 1'b1;
                    tmr_val    = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, latched mine count, reveal counter and captured move attributes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mine_count_q <= '0;
            revealed_q   <= '0;
            cap_mine_q   <= 1'b0;
            cap_open_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            mine_count_q <= mine_count_d;
            revealed_q   <= revealed_d;
            cap_mine_q   <= cap_mine_d;
            cap_open_q   <= cap_open_d;
        end
    end

    turn_timer #(
        .TICK_W (TICK_W)
    ) u_turn_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .en_i       (tmr_en),
        .count_o    (tmr_count),
        .zero_o     (tmr_zero)
    );

    assign state      = state_q;
    assign move_ready = (state_q == S_PLAY);
    assign place_req  = (state_q == S_SETUP);
    assign win        = (state_q == S_WIN);
    assign lose       = (state_q == S_LOSE);
    assign mine_count = mine_count_q;
    assign revealed   = revealed_q;
    assign time_left  = tmr_count;

endmodule
